// File: rtl/bpu_update_queue.sv
// Commit-side branch-training queue: compacts retiring control transfers into a FIFO
// drained one update per cycle, and forwards per-slot call/return events to the RAS.
package config_pkg;
   typedef struct packed {
      int unsigned NRET;
      int unsigned PLEN;
   } cfg_t;

   localparam cfg_t EmptyCfg = '{NRET: 32'd4, PLEN: 32'd32};
endpackage

module bpu_update_queue #(
   parameter config_pkg::cfg_t Cfg         = config_pkg::EmptyCfg,
   parameter int unsigned      QUEUE_DEPTH = 8
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic [Cfg.NRET-1:0]                      commit_valid_i,
   input  logic [Cfg.NRET-1:0]                      commit_is_branch_i,
   input  logic [Cfg.NRET-1:0]                      commit_is_cond_i,
   input  logic [Cfg.NRET-1:0]                      commit_taken_i,
   input  logic [Cfg.NRET-1:0]                      commit_is_call_i,
   input  logic [Cfg.NRET-1:0]                      commit_is_ret_i,
   input  logic [Cfg.NRET-1:0][Cfg.PLEN-1:0]        commit_pc_i,
   input  logic [Cfg.NRET-1:0][Cfg.PLEN-1:0]        commit_target_i,
   output logic                                     commit_ready_o,
   output logic                                     update_valid_o,
   output logic [Cfg.PLEN-1:0]                      update_pc_o,
   output logic                                     update_is_cond_o,
   output logic                                     update_taken_o,
   output logic [Cfg.PLEN-1:0]                      update_target_o,
   output logic                                     update_is_call_o,
   output logic                                     update_is_ret_o,
   output logic [Cfg.NRET-1:0]                      ras_update_valid_o,
   output logic [Cfg.NRET-1:0]                      ras_update_is_call_o,
   output logic [Cfg.NRET-1:0]                      ras_update_is_ret_o,
   output logic [Cfg.NRET-1:0][Cfg.PLEN-1:0]        ras_update_pc_o,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]         occupancy_o,
   output logic                                     overflow_o
);

   localparam int unsigned NRET = Cfg.NRET;
   localparam int unsigned PLEN = Cfg.PLEN;
   localparam int unsigned PW   = $clog2(QUEUE_DEPTH);
   localparam int unsigned CW   = $clog2(QUEUE_DEPTH + 1);

   typedef struct packed {
      logic [PLEN-1:0] pc;
      logic [PLEN-1:0] target;
      logic            is_cond;
      logic            taken;
      logic            is_call;
      logic            is_ret;
   } entry_t;

   logic [CW-1:0]             count_q, count_d;
   logic [PW-1:0]             wptr_q, wptr_d;
   logic [PW-1:0]             rptr_q, rptr_d;
   entry_t                    mem_q [QUEUE_DEPTH];
   entry_t                    mem_d [QUEUE_DEPTH];
   entry_t                    upd_q, upd_d;
   logic                      upd_valid_q, upd_valid_d;
   logic [NRET-1:0]           ras_valid_q, ras_valid_d;
   logic [NRET-1:0]           ras_call_q, ras_call_d;
   logic [NRET-1:0]           ras_ret_q, ras_ret_d;
   logic [NRET-1:0][PLEN-1:0] ras_pc_q, ras_pc_d;
   logic                      overflow_q, overflow_d;

   logic                      ready_s;
   logic                      accept_s;
   logic                      pop_s;
   logic [CW-1:0]             push_cnt_s;
   logic [PW-1:0]             widx_s;

   // Ready looks only at the registered count so a full group always fits.
   assign ready_s  = (count_q <= CW'(QUEUE_DEPTH - NRET));
   assign accept_s = ready_s && (|commit_valid_i);
   assign pop_s    = (count_q != {CW{1'b0}});

   // Compact branch slots into consecutive FIFO locations starting at the write pointer.
   always_comb begin
      mem_d      = mem_q;
      push_cnt_s = {CW{1'b0}};
      widx_s     = wptr_q;
      for (int i = 0; i < int'(NRET); i++) begin
         if (accept_s && commit_valid_i[i] && commit_is_branch_i[i]) begin
            widx_s                 = wptr_q + push_cnt_s[PW-1:0];
            mem_d[widx_s].pc       = commit_pc_i[i];
            mem_d[widx_s].target   = commit_target_i[i];
            mem_d[widx_s].is_cond  = commit_is_cond_i[i];
            mem_d[widx_s].taken    = commit_is_cond_i[i] ? commit_taken_i[i] : 1'b1;
            mem_d[widx_s].is_call  = commit_is_call_i[i];
            mem_d[widx_s].is_ret   = commit_is_ret_i[i];
            push_cnt_s             = push_cnt_s + CW'(1);
         end else begin
            push_cnt_s = push_cnt_s;
         end
      end
   end

   // Pointer, count, drain and RAS next-state.
   always_comb begin
      wptr_d     = wptr_q + push_cnt_s[PW-1:0];
      rptr_d     = rptr_q + PW'(pop_s);
      count_d    = count_q + push_cnt_s - CW'(pop_s);
      overflow_d = overflow_q | ((|commit_valid_i) & ~ready_s);
      if (pop_s) begin
         upd_valid_d = 1'b1;
         upd_d       = mem_q[rptr_q];
      end else begin
         upd_valid_d = 1'b0;
         upd_d       = upd_q;
      end
      for (int i = 0; i < int'(NRET); i++) begin
         ras_valid_d[i] = accept_s && commit_valid_i[i] && commit_is_branch_i[i]
                          && (commit_is_call_i[i] || commit_is_ret_i[i]);
      end
      ras_call_d = commit_is_call_i;
      ras_ret_d  = commit_is_ret_i;
      ras_pc_d   = commit_pc_i;
   end

   // FIFO storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q     <= {CW{1'b0}};
         wptr_q      <= {PW{1'b0}};
         rptr_q      <= {PW{1'b0}};
         upd_q       <= '0;
         upd_valid_q <= 1'b0;
         ras_valid_q <= {NRET{1'b0}};
         ras_call_q  <= {NRET{1'b0}};
         ras_ret_q   <= {NRET{1'b0}};
         ras_pc_q    <= '0;
         overflow_q  <= 1'b0;
      end else begin
         count_q     <= count_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         upd_q       <= upd_d;
         upd_valid_q <= upd_valid_d;
         ras_valid_q <= ras_valid_d;
         ras_call_q  <= ras_call_d;
         ras_ret_q   <= ras_ret_d;
         ras_pc_q    <= ras_pc_d;
         overflow_q  <= overflow_d;
      end
   end

   assign commit_ready_o       = ready_s;
   assign update_valid_o       = upd_valid_q;
   assign update_pc_o          = upd_q.pc;
   assign update_is_cond_o     = upd_q.is_cond;
   assign update_taken_o       = upd_q.taken;
   assign update_target_o      = upd_q.target;
   assign update_is_call_o     = upd_q.is_call;
   assign update_is_ret_o      = upd_q.is_ret;
   assign ras_update_valid_o   = ras_valid_q;
   assign ras_update_is_call_o = ras_call_q;
   assign ras_update_is_ret_o  = ras_ret_q;
   assign ras_update_pc_o      = ras_pc_q;
   assign occupancy_o          = count_q;
   assign overflow_o           = overflow_q;

endmodule

// File: tb/tb_bpu_update_queue.sv
// Self-checking bench for bpu_update_queue: directed vector table, hand-written
// corner sequences, and random traffic against a queue-level reference model.
module tb_bpu_update_queue;

   localparam int NRET = 4;
   localparam int PLEN = 32;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst_i;
   logic [NRET-1:0] c_valid, c_branch, c_cond, c_taken, c_call, c_ret;
   logic [NRET-1:0][PLEN-1:0] c_pc, c_tgt;
   logic commit_ready_o, update_valid_o, update_is_cond_o, update_taken_o;
   logic update_is_call_o, update_is_ret_o, overflow_o;
   logic [PLEN-1:0] update_pc_o, update_target_o;
   logic [NRET-1:0] ras_update_valid_o, ras_update_is_call_o, ras_update_is_ret_o;
   logic [NRET-1:0][PLEN-1:0] ras_update_pc_o;
   logic [3:0] occupancy_o;

   always #5 clk = ~clk;

   bpu_update_queue #(.QUEUE_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .commit_valid_i(c_valid), .commit_is_branch_i(c_branch),
      .commit_is_cond_i(c_cond), .commit_taken_i(c_taken),
      .commit_is_call_i(c_call), .commit_is_ret_i(c_ret),
      .commit_pc_i(c_pc), .commit_target_i(c_tgt),
      .commit_ready_o(commit_ready_o),
      .update_valid_o(update_valid_o), .update_pc_o(update_pc_o),
      .update_is_cond_o(update_is_cond_o), .update_taken_o(update_taken_o),
      .update_target_o(update_target_o), .update_is_call_o(update_is_call_o),
      .update_is_ret_o(update_is_ret_o),
      .ras_update_valid_o(ras_update_valid_o), .ras_update_is_call_o(ras_update_is_call_o),
      .ras_update_is_ret_o(ras_update_is_ret_o), .ras_update_pc_o(ras_update_pc_o),
      .occupancy_o(occupancy_o), .overflow_o(overflow_o)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        cond;
      logic        taken;
      logic        call;
      logic        ret;
   } ent_t;

   typedef struct {
      logic [3:0]  v, b, cd, tk, cl, rt;
      logic [31:0] pbase, tbase;
      logic        e_uv;
      logic [31:0] e_upc;
      int          e_occ;
      logic        e_rdy;
      logic [3:0]  e_rasv;
   } vec_t;

   int checks = 0;
   int failures = 0;

   ent_t       mq[$];
   ent_t       exp_upd;
   logic       exp_upd_valid;
   logic [3:0] exp_ras_valid, exp_ras_call, exp_ras_ret;
   logic [3:0][31:0] exp_ras_pc;
   logic       exp_ovf;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      c_valid = '0; c_branch = '0; c_cond = '0; c_taken = '0;
      c_call = '0; c_ret = '0; c_pc = '0; c_tgt = '0;
   endtask

   task automatic drive(input logic [3:0] v, b, cd, tk, cl, rt, input logic [31:0] pbase, tbase);
      c_valid = v; c_branch = b; c_cond = cd; c_taken = tk; c_call = cl; c_ret = rt;
      for (int i = 0; i < NRET; i++) begin
         c_pc[i]  = pbase + 32'(4 * i);
         c_tgt[i] = tbase + 32'(4 * i);
      end
   endtask

   // Advance the reference model by one edge using the current inputs, then compare.
   task automatic tick();
      bit   ready_m, acc;
      ent_t e;
      ready_m = (DEPTH - mq.size()) >= NRET;
      if (rst_i) begin
         mq.delete();
         exp_upd = '0; exp_upd_valid = 1'b0; exp_ovf = 1'b0;
         exp_ras_valid = '0; exp_ras_call = '0; exp_ras_ret = '0; exp_ras_pc = '0;
      end else begin
         acc = ready_m && (c_valid != 4'b0);
         if (c_valid != 4'b0 && !ready_m) exp_ovf = 1'b1;
         if (mq.size() != 0) begin
            exp_upd = mq.pop_front();
            exp_upd_valid = 1'b1;
         end else begin
            exp_upd_valid = 1'b0;
         end
         exp_ras_valid = '0;
         for (int i = 0; i < NRET; i++) begin
            if (acc && c_valid[i] && c_branch[i]) begin
               e.pc = c_pc[i]; e.tgt = c_tgt[i]; e.cond = c_cond[i];
               e.taken = c_cond[i] ? c_taken[i] : 1'b1;
               e.call = c_call[i]; e.ret = c_ret[i];
               mq.push_back(e);
               exp_ras_valid[i] = c_call[i] | c_ret[i];
            end
            exp_ras_pc[i] = c_pc[i]; exp_ras_call[i] = c_call[i]; exp_ras_ret[i] = c_ret[i];
         end
      end
      @(posedge clk);
      #1;
      check("upd_valid", 64'(update_valid_o), 64'(exp_upd_valid));
      check("upd_pc", 64'(update_pc_o), 64'(exp_upd.pc));
      check("upd_target", 64'(update_target_o), 64'(exp_upd.tgt));
      check("upd_cond", 64'(update_is_cond_o), 64'(exp_upd.cond));
      check("upd_taken", 64'(update_taken_o), 64'(exp_upd.taken));
      check("upd_call", 64'(update_is_call_o), 64'(exp_upd.call));
      check("upd_ret", 64'(update_is_ret_o), 64'(exp_upd.ret));
      check("occupancy", 64'(occupancy_o), 64'(mq.size()));
      check("ready", 64'(commit_ready_o), 64'((DEPTH - mq.size()) >= NRET));
      check("overflow", 64'(overflow_o), 64'(exp_ovf));
      check("ras_valid", 64'(ras_update_valid_o), 64'(exp_ras_valid));
      for (int i = 0; i < NRET; i++) begin
         if (exp_ras_valid[i]) begin
            check("ras_pc", 64'(ras_update_pc_o[i]), 64'(exp_ras_pc[i]));
            check("ras_call", 64'(ras_update_is_call_o[i]), 64'(exp_ras_call[i]));
            check("ras_ret", 64'(ras_update_is_ret_o[i]), 64'(exp_ras_ret[i]));
         end
      end
   endtask

   function automatic vec_t mk(input logic [3:0] v, b, cd, tk, cl, rt,
                               input logic [31:0] pbase, tbase, input logic uv,
                               input logic [31:0] upc, input int occ, input logic rdy,
                               input logic [3:0] rasv);
      vec_t r;
      r.v = v; r.b = b; r.cd = cd; r.tk = tk; r.cl = cl; r.rt = rt;
      r.pbase = pbase; r.tbase = tbase; r.e_uv = uv; r.e_upc = upc;
      r.e_occ = occ; r.e_rdy = rdy; r.e_rasv = rasv;
      return r;
   endfunction

   initial begin
      vec_t vt[6];
      logic [31:0] wlist[8];

      // Single conditional branch, then the mixed-slot group.
      vt[0] = mk(4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
                 32'h8000_0008, 32'h8000_0038, 1'b0, 32'h0, 1, 1'b1, 4'b0000);
      vt[1] = mk(4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 32'h0, 32'h0,
                 1'b1, 32'h8000_0010, 0, 1'b1, 4'b0000);
      vt[2] = mk(4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 32'h0, 32'h0,
                 1'b0, 32'h0, 0, 1'b1, 4'b0000);
      vt[3] = mk(4'b0111, 4'b1101, 4'b0000, 4'b0000, 4'b1011, 4'b0100,
                 32'h300, 32'h400, 1'b0, 32'h0, 2, 1'b1, 4'b0101);
      vt[4] = mk(4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 32'h0, 32'h0,
                 1'b1, 32'h300, 1, 1'b1, 4'b0000);
      vt[5] = mk(4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 32'h0, 32'h0,
                 1'b1, 32'h308, 0, 1'b1, 4'b0000);

      idle();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;

      for (int n = 0; n < 6; n++) begin
         drive(vt[n].v, vt[n].b, vt[n].cd, vt[n].tk, vt[n].cl, vt[n].rt, vt[n].pbase, vt[n].tbase);
         tick();
         check("vec_upd_valid", 64'(update_valid_o), 64'(vt[n].e_uv));
         if (vt[n].e_uv) check("vec_upd_pc", 64'(update_pc_o), 64'(vt[n].e_upc));
         check("vec_occ", 64'(occupancy_o), 64'(vt[n].e_occ));
         check("vec_ready", 64'(commit_ready_o), 64'(vt[n].e_rdy));
         check("vec_ras_valid", 64'(ras_update_valid_o), 64'(vt[n].e_rasv));
      end

      // Full groups across the pointer wrap: pre-advance pointers to 6 first.
      drive(4'b0111, 4'b0111, 4'b0, 4'b0, 4'b0, 4'b0, 32'h500, 32'h0); tick();
      drive(4'b0111, 4'b0111, 4'b0, 4'b0, 4'b0, 4'b0, 32'h540, 32'h0); tick();
      idle();
      for (int n = 0; n < 8; n++) tick();
      for (int k = 0; k < 8; k++) wlist[k] = (k < 4) ? 32'h100 + 32'(4 * k) : 32'h200 + 32'(4 * (k - 4));
      drive(4'b1111, 4'b1111, 4'b0101, 4'b0001, 4'b0, 4'b0, 32'h100, 32'h1100); tick();
      check("wrap_occ_a", 64'(occupancy_o), 64'd4);
      drive(4'b1111, 4'b1111, 4'b0, 4'b0, 4'b0, 4'b0, 32'h200, 32'h1200); tick();
      check("wrap_occ_b", 64'(occupancy_o), 64'd7);
      check("wrap_ready_b", 64'(commit_ready_o), 64'd0);
      check("wrap_upd0", 64'(update_pc_o), 64'(wlist[0]));
      idle();
      for (int j = 1; j < 8; j++) begin
         tick();
         check("wrap_upd_valid", 64'(update_valid_o), 64'd1);
         check("wrap_upd_pc", 64'(update_pc_o), 64'(wlist[j]));
         check("wrap_occ", 64'(occupancy_o), 64'(7 - j));
         check("wrap_ready", 64'(commit_ready_o), 64'((7 - j) <= 4));
      end
      tick();
      check("wrap_drained", 64'(update_valid_o), 64'd0);

      // Protocol violation: group presented at occupancy 7 is discarded.
      drive(4'b1111, 4'b1111, 4'b0, 4'b0, 4'b0, 4'b0, 32'h600, 32'h0); tick();
      drive(4'b1111, 4'b1111, 4'b0, 4'b0, 4'b0, 4'b0, 32'h700, 32'h0); tick();
      drive(4'b1111, 4'b1111, 4'b0, 4'b0, 4'b1111, 4'b0, 32'h900, 32'h0); tick();
      check("viol_overflow", 64'(overflow_o), 64'd1);
      check("viol_ras", 64'(ras_update_valid_o), 64'd0);
      check("viol_occ", 64'(occupancy_o), 64'd6);
      idle();
      for (int n = 0; n < 8; n++) begin
         tick();
         check("viol_sticky", 64'(overflow_o), 64'd1);
      end
      check("viol_drained", 64'(occupancy_o), 64'd0);

      // Reset with occupancy 5.
      drive(4'b1111, 4'b1111, 4'b0, 4'b0, 4'b0, 4'b0, 32'hA00, 32'h0); tick();
      drive(4'b0011, 4'b0011, 4'b0, 4'b0, 4'b0, 4'b0, 32'hB00, 32'h0); tick();
      check("mid_occ5", 64'(occupancy_o), 64'd5);
      idle();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("rst_upd_valid", 64'(update_valid_o), 64'd0);
      check("rst_occ", 64'(occupancy_o), 64'd0);
      check("rst_overflow", 64'(overflow_o), 64'd0);
      check("rst_ready", 64'(commit_ready_o), 64'd1);
      for (int n = 0; n < 6; n++) begin
         tick();
         check("rst_no_stale", 64'(update_valid_o), 64'd0);
      end

      // Random traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         rst_i = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 1) == 1) begin
            c_valid = 4'($urandom); c_branch = 4'($urandom); c_cond = 4'($urandom);
            c_taken = 4'($urandom); c_call = 4'($urandom); c_ret = 4'($urandom);
            for (int i = 0; i < NRET; i++) begin
               c_pc[i] = $urandom; c_tgt[i] = $urandom;
            end
         end else begin
            idle();
         end
         tick();
      end
      rst_i = 1'b0;
      idle();
      for (int n = 0; n < 10; n++) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
